// File: rtl/sigma_delta_decimator.sv
// Third-order CIC (sinc^3) decimator: turns an oversampled 1-bit sigma-delta
// stream into signed WIDTH-bit PCM at one sample per 2**LOG2_RATE enabled inputs.
module sigma_delta_decimator #(
  parameter int WIDTH     = 16,
  parameter int LOG2_RATE = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sdIn,
  output logic signed [WIDTH-1:0] pcmOut,
  output logic                    outValid,
  output logic                    outSat
);

  localparam int ACC_W = 3 * LOG2_RATE + 2;
  localparam int SHIFT = 3 * LOG2_RATE - WIDTH + 1;

  localparam logic [LOG2_RATE-1:0]    CNT_MAX = '1;
  localparam logic [1:0]              PRIMED  = 2'd2;
  localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] PCM_MIN = ACC_W'(-(1 <<< (WIDTH - 1)));
  localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

  // The lower bound is unreachable for a sinc^3 of a +-1 stream but is still guarded.
  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    return (v > PCM_MAX) || (v < PCM_MIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [ACC_W-1:0] v);
    if (v > PCM_MAX) return OUT_MAX;
    if (v < PCM_MIN) return OUT_MIN;
    return v[WIDTH-1:0];
  endfunction

  logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [ACC_W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic        [LOG2_RATE-1:0] cnt_q, cnt_d;
  logic        [1:0]           prime_q, prime_d;
  logic signed [WIDTH-1:0]     pcm_q, pcm_d;
  logic                        vld_q, vld_d;
  logic                        sat_q, sat_d;

  logic signed [ACC_W-1:0] x_s, i1_n, i2_n, i3_n, c1, c2, c3, y;
  logic                    strobe;

  always_comb begin
    x_s     = sdIn ? {{(ACC_W - 1){1'b0}}, 1'b1} : '1;
    i1_n    = i1_q + x_s;
    i2_n    = i2_q + i1_n;
    i3_n    = i3_q + i2_n;
    c1      = i3_n - d0_q;
    c2      = c1 - d1_q;
    c3      = c2 - d2_q;
    y       = c3 >>> SHIFT;
    strobe  = en && (cnt_q == CNT_MAX);

    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    cnt_d   = cnt_q;
    prime_d = prime_q;
    pcm_d   = pcm_q;
    sat_d   = sat_q;
    vld_d   = 1'b0;

    if (en) begin
      i1_d  = i1_n;
      i2_d  = i2_n;
      i3_d  = i3_n;
      cnt_d = cnt_q + LOG2_RATE'(1);
    end

    // Comb delays advance only at the decimated rate; the first two frames only prime them.
    if (strobe) begin
      d0_d = i3_n;
      d1_d = c1;
      d2_d = c2;
      if (prime_q == PRIMED) begin
        vld_d = 1'b1;
        pcm_d = clamp(y);
        sat_d = sat_hit(y);
      end else begin
        prime_d = prime_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      cnt_q   <= '0;
      prime_q <= '0;
      pcm_q   <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      pcm_q   <= pcm_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
    end
  end

  assign pcmOut   = pcm_q;
  assign outValid = vld_q;
  assign outSat   = sat_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator: directed scenarios plus random streams,
// checked against a direct sinc^3 convolution model of the input history.
module tb_sigma_delta_decimator;

  localparam int W     = 16;
  localparam int L     = 6;
  localparam int R     = 1 << L;
  localparam int KLEN  = 3 * R - 2;
  localparam int SHIFT = 3 * L - W + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                sdIn = 1'b0;
  logic signed [W-1:0] pcmOut;
  logic                outValid;
  logic                outSat;

  sigma_delta_decimator #(.WIDTH(W), .LOG2_RATE(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sdIn     (sdIn),
    .pcmOut   (pcmOut),
    .outValid (outValid),
    .outSat   (outSat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: sinc^3 kernel and the recent +-1 input history.
  longint h2[2*R-1];
  longint h3[KLEN];
  int     hist[$];
  int     n_in;
  int     cyc;
  logic signed [W-1:0] exp_pcm;
  logic                exp_sat;
  logic                exp_vld;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic build_kernel();
    for (int i = 0; i < 2*R-1; i++) h2[i] = 0;
    for (int i = 0; i < KLEN; i++) h3[i] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++) h2[a+b] += 1;
    for (int k = 0; k < 2*R-1; k++)
      for (int c = 0; c < R; c++) h3[k+c] += h2[k];
  endtask

  task automatic model_output();
    longint acc = 0;
    longint yv;
    int     last = hist.size() - 1;
    for (int j = 0; j < KLEN; j++) acc += h3[j] * longint'(hist[last-j]);
    yv = floor_div(acc, longint'(1) << SHIFT);
    exp_sat = 1'b0;
    if (yv > (longint'(1) << (W-1)) - 1) begin
      yv = (longint'(1) << (W-1)) - 1;
      exp_sat = 1'b1;
    end else if (yv < -(longint'(1) << (W-1))) begin
      yv = -(longint'(1) << (W-1));
      exp_sat = 1'b1;
    end
    exp_pcm = W'(yv);
  endtask

  task automatic step(input logic r, input logic e, input logic b);
    rst = r; en = e; sdIn = b;
    @(posedge clk);
    #1;
    cyc++;
    exp_vld = 1'b0;
    if (r) begin
      hist.delete();
      n_in    = 0;
      exp_pcm = '0;
      exp_sat = 1'b0;
    end else if (e) begin
      hist.push_back(b ? 1 : -1);
      if (hist.size() > 3*R) void'(hist.pop_front());
      n_in++;
      if ((n_in % R == 0) && (n_in / R >= 3)) begin
        model_output();
        exp_vld = 1'b1;
      end
    end
    chk("outValid", 32'(outValid), 32'(exp_vld));
    chk("pcmOut", 32'(pcmOut), 32'(exp_pcm));
    if (r || exp_vld) chk("outSat", 32'(outSat), 32'(exp_sat));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom));
  endtask

  int last_v;
  int p;
  logic [3:0] pat;

  initial begin
    build_kernel();
    n_in = 0; cyc = 0;
    exp_pcm = '0; exp_sat = 1'b0; exp_vld = 1'b0;

    // T1: constant ones saturate at the positive rail.
    do_reset(2);
    for (int i = 0; i < 6*R; i++) step(1'b0, 1'b1, 1'b1);
    chk("T1 pcm", 32'(pcmOut), 32'sd32767);
    chk("T1 sat", 32'(outSat), 32'd1);

    // T2: constant zeros reach the negative full scale without saturating.
    do_reset(2);
    for (int i = 0; i < 6*R; i++) step(1'b0, 1'b1, 1'b0);
    chk("T2 pcm", 32'(pcmOut), -32'sd32768);
    chk("T2 sat", 32'(outSat), 32'd0);

    // T3: alternating bits average to zero.
    do_reset(2);
    for (int i = 0; i < 6*R; i++) step(1'b0, 1'b1, 1'((i + 1) % 2));
    chk("T3 pcm", 32'(pcmOut), 32'sd0);

    // T4 with T6 reset pulse at cnt=30, then the 1,1,1,0 switch.
    pat = 4'b0001;
    do_reset(2);
    for (int i = 0; i < 6*R; i++) step(1'b0, 1'b1, pat[i%4]);
    chk("T4 pcm", 32'(pcmOut), -32'sd16384);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, pat[i%4]);
    step(1'b1, 1'b1, 1'b1);
    chk("T6 pcm clr", 32'(pcmOut), 32'sd0);
    chk("T6 vld clr", 32'(outValid), 32'd0);
    for (int i = 0; i < 6*R; i++) step(1'b0, 1'b1, pat[i%4]);
    chk("T6 pcm", 32'(pcmOut), -32'sd16384);
    pat = 4'b0111;
    for (int i = 0; i < 3*R; i++) step(1'b0, 1'b1, pat[i%4]);
    chk("T4 switch pcm", 32'(pcmOut), 32'sd16384);

    // T5: en at half rate; sdIn is random noise on disabled cycles.
    do_reset(2);
    last_v = -1;
    for (int i = 0; i < 12*R; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 1'b1);
      else            step(1'b0, 1'b0, 1'($urandom));
      if (outValid) begin
        if (last_v >= 0) chk("T5 spacing", 32'(cyc - last_v), 32'd128);
        last_v = cyc;
      end
    end
    chk("T5 pcm", 32'(pcmOut), 32'sd32767);

    // Random streams with per-segment density, random enables and rare resets.
    do_reset(2);
    for (int s = 0; s < 8; s++) begin
      p = $urandom_range(0, 100);
      for (int i = 0; i < 4*R; i++)
        step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 99) < p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
